// File: rtl/hsv_pkg.sv
// Constants shared by the RGB<->HSV converter pair: angle/scale units,
// sector offsets, pipeline depth and the max-channel selector encoding.
package hsv_pkg;

    localparam int unsigned H_FULL     = 360;
    localparam int unsigned S_ONE      = 256;
    localparam int unsigned SECTOR_DEG = 60;
    localparam int unsigned OFS_R      = 0;
    localparam int unsigned OFS_G      = 120;
    localparam int unsigned OFS_B      = 240;
    localparam int unsigned PIPE_LAT   = 4;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } maxsel_t;

endpackage

// File: rtl/sync_delay.sv
// Multi-lane shift register that keeps video syncs aligned with pipelined
// pixel data; each lane is delayed independently by DEPTH clocks.
module sync_delay #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LANES-1:0] din,
    output logic [LANES-1:0] dout
);

    logic [LANES-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/rgb_hsv.sv
// Four-stage RGB888 -> HSV converter (H in degrees, S with 256 = 1.0),
// one pixel per clock, syncs delayed alongside the data.
module rgb_hsv
    import hsv_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_rgb_r,
    input  logic [7:0] i_rgb_g,
    input  logic [7:0] i_rgb_b,
    input  logic       vs,
    input  logic       hs,
    input  logic       de,
    output logic [8:0] o_hsv_h,
    output logic [8:0] o_hsv_s,
    output logic [7:0] o_hsv_v,
    output logic       hsv_vs,
    output logic       hsv_hs,
    output logic       hsv_de
);

    // stage 1
    logic [7:0]        r1, g1, b1, max1, min1;
    maxsel_t           sel1;
    logic [7:0]        max_c, min_c;
    maxsel_t           sel_c;
    // stage 2
    logic [7:0]        delta2, max2;
    logic signed [8:0] num2;
    logic [8:0]        ofs2;
    maxsel_t           sel2;
    logic signed [8:0] num_c;
    logic [8:0]        ofs_c;
    logic [7:0]        mag_c;
    // stage 3
    logic [8:0]        s3, ofs3;
    logic [5:0]        frac3;
    logic              neg3, grey3;
    logic [7:0]        max3;
    maxsel_t           sel3;
    logic [2:0]        sync_out;

    // Ties go to the earlier channel in R, G, B order.
    always_comb begin
        max_c = i_rgb_r;
        sel_c = SEL_R;
        if (!(i_rgb_r >= i_rgb_g && i_rgb_r >= i_rgb_b)) begin
            if (i_rgb_g >= i_rgb_b) begin
                max_c = i_rgb_g;
                sel_c = SEL_G;
            end else begin
                max_c = i_rgb_b;
                sel_c = SEL_B;
            end
        end
        min_c = i_rgb_r;
        if (i_rgb_g < min_c) min_c = i_rgb_g;
        if (i_rgb_b < min_c) min_c = i_rgb_b;
    end

    always_comb begin
        num_c = $signed({1'b0, g1}) - $signed({1'b0, b1});
        ofs_c = 9'(OFS_R);
        case (sel1)
            SEL_G: begin
                num_c = $signed({1'b0, b1}) - $signed({1'b0, r1});
                ofs_c = 9'(OFS_G);
            end
            SEL_B: begin
                num_c = $signed({1'b0, r1}) - $signed({1'b0, g1});
                ofs_c = 9'(OFS_B);
            end
            default: ;
        endcase
        mag_c = num2[8] ? 8'(-num2) : 8'(num2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1 <= '0; g1 <= '0; b1 <= '0; max1 <= '0; min1 <= '0; sel1 <= SEL_R;
            delta2 <= '0; max2 <= '0; num2 <= '0; ofs2 <= '0; sel2 <= SEL_R;
            s3 <= '0; ofs3 <= '0; frac3 <= '0; neg3 <= 1'b0; grey3 <= 1'b0;
            max3 <= '0; sel3 <= SEL_R;
            o_hsv_h <= '0; o_hsv_s <= '0; o_hsv_v <= '0;
        end else begin
            r1   <= i_rgb_r;
            g1   <= i_rgb_g;
            b1   <= i_rgb_b;
            max1 <= max_c;
            min1 <= min_c;
            sel1 <= sel_c;

            delta2 <= max1 - min1;
            max2   <= max1;
            num2   <= num_c;
            ofs2   <= ofs_c;
            sel2   <= sel1;

            s3    <= (max2 == '0) ? '0
                   : 9'((16'(delta2) * 16'(S_ONE)) / {8'd0, max2});
            frac3 <= (delta2 == '0) ? '0
                   : 6'((14'(mag_c) * 14'(SECTOR_DEG)) / {6'd0, delta2});
            neg3  <= num2[8];
            grey3 <= (delta2 == '0);
            ofs3  <= ofs2;
            max3  <= max2;
            sel3  <= sel2;

            // Negative hue in the red sector wraps below 360; 360 itself folds to 0.
            if (grey3)
                o_hsv_h <= '0;
            else if (!neg3)
                o_hsv_h <= ofs3 + 9'(frac3);
            else if (sel3 == SEL_R)
                o_hsv_h <= (frac3 == '0) ? '0 : 9'(H_FULL) - 9'(frac3);
            else
                o_hsv_h <= ofs3 - 9'(frac3);
            o_hsv_s <= grey3 ? '0 : s3;
            o_hsv_v <= max3;
        end
    end

    sync_delay #(
        .DEPTH(PIPE_LAT),
        .LANES(3)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    ({vs, hs, de}),
        .dout   (sync_out)
    );

    assign {hsv_vs, hsv_hs, hsv_de} = sync_out;

endmodule

// File: tb/tb_rgb_hsv.sv
// Scoreboard bench for rgb_hsv: expected HSV and syncs are queued with the
// clock on which they must appear; a monitor compares each due entry.
module tb_rgb_hsv;
    import hsv_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] i_rgb_r = '0, i_rgb_g = '0, i_rgb_b = '0;
    logic       vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic [8:0] o_hsv_h, o_hsv_s;
    logic [7:0] o_hsv_v;
    logic       hsv_vs, hsv_hs, hsv_de;

    typedef struct {
        int unsigned due;
        int          h, s, v;
        logic        vs, hs, de;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    rgb_hsv dut (
        .clk    (clk),
        .reset_n(reset_n),
        .i_rgb_r(i_rgb_r),
        .i_rgb_g(i_rgb_g),
        .i_rgb_b(i_rgb_b),
        .vs     (vs),
        .hs     (hs),
        .de     (de),
        .o_hsv_h(o_hsv_h),
        .o_hsv_s(o_hsv_s),
        .o_hsv_v(o_hsv_v),
        .hsv_vs (hsv_vs),
        .hsv_hs (hsv_hs),
        .hsv_de (hsv_de)
    );

    always #5 clk = ~clk;

    // Reference conversion in plain integer arithmetic.
    function automatic void model(input int rr, input int gg, input int bb,
                                  output int h, output int s, output int v);
        int mx, mn, d, num, ofs, frac;
        bit red_sector;
        mx = rr; mn = rr;
        if (gg > mx) mx = gg;
        if (bb > mx) mx = bb;
        if (gg < mn) mn = gg;
        if (bb < mn) mn = bb;
        v = mx;
        d = mx - mn;
        red_sector = 1'b0;
        if (rr >= gg && rr >= bb) begin
            num = gg - bb; ofs = 0; red_sector = 1'b1;
        end else if (gg >= bb) begin
            num = bb - rr; ofs = 120;
        end else begin
            num = rr - gg; ofs = 240;
        end
        if (d == 0) begin
            h = 0; s = 0;
        end else begin
            s    = (d * 256) / mx;
            frac = ((num < 0) ? -num : num) * 60 / d;
            if (num >= 0)       h = ofs + frac;
            else if (red_sector) h = 360 - frac;
            else                 h = ofs - frac;
            if (h == 360) h = 0;
        end
    endfunction

    task automatic drive(input int rr, input int gg, input int bb,
                         input logic vv, input logic hh, input logic dd,
                         input bit directed, input int eh, input int es, input int ev);
        exp_t e;
        int mh, ms, mv;
        @(negedge clk);
        i_rgb_r = 8'(rr); i_rgb_g = 8'(gg); i_rgb_b = 8'(bb);
        vs = vv; hs = hh; de = dd;
        if (directed) begin
            mh = eh; ms = es; mv = ev;
        end else begin
            model(rr, gg, bb, mh, ms, mv);
        end
        e.due = cyc + 4;
        e.h = mh; e.s = ms; e.v = mv;
        e.vs = vv; e.hs = hh; e.de = dd;
        q.push_back(e);
    endtask

    task automatic rand_pix();
        drive($urandom_range(255), $urandom_range(255), $urandom_range(255),
              1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 0, 0, 0);
    endtask

    // Asserts reset for one clock; in-flight pixels are discarded and the
    // pipeline must read all-zero until fresh pixels emerge.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset_n = 1'b0;
        i_rgb_r = '0; i_rgb_g = '0; i_rgb_b = '0;
        vs = 1'b0; hs = 1'b0; de = 1'b0;
        q.delete();
        #1;
        n_chk++;
        if ({o_hsv_h, o_hsv_s, o_hsv_v, hsv_vs, hsv_hs, hsv_de} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got h=%0d s=%0d v=%0d vs=%b hs=%b de=%b, want all 0",
                     o_hsv_h, o_hsv_s, o_hsv_v, hsv_vs, hsv_hs, hsv_de);
        end
        for (int unsigned k = 1; k <= 4; k++) begin
            e.due = cyc + k;
            e.h = 0; e.s = 0; e.v = 0;
            e.vs = 1'b0; e.hs = 1'b0; e.de = 1'b0;
            q.push_back(e);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_chk++;
                if (e.due != cyc || o_hsv_h !== 9'(e.h) || o_hsv_s !== 9'(e.s) ||
                    o_hsv_v !== 8'(e.v) || hsv_vs !== e.vs || hsv_hs !== e.hs ||
                    hsv_de !== e.de) begin
                    n_fail++;
                    $display("FAIL pixel@cyc%0d (due %0d): got h=%0d s=%0d v=%0d vs=%b hs=%b de=%b, want h=%0d s=%0d v=%0d vs=%b hs=%b de=%b",
                             cyc, e.due, o_hsv_h, o_hsv_s, o_hsv_v, hsv_vs, hsv_hs, hsv_de,
                             e.h, e.s, e.v, e.vs, e.hs, e.de);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries still queued", q.size());
        $fatal(1, "watchdog");
    end

    initial begin : stim
        do_reset();

        // primaries on consecutive clocks
        drive(255, 0, 0,   1'b0, 1'b0, 1'b1, 1'b1, 0,   256, 255);
        drive(0, 255, 0,   1'b0, 1'b0, 1'b1, 1'b1, 120, 256, 255);
        drive(0, 0, 255,   1'b0, 1'b0, 1'b1, 1'b1, 240, 256, 255);
        // greys
        drive(0, 0, 0,       1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        drive(128, 128, 128, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 128);
        drive(255, 255, 255, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 255);
        // ties and hue wrap
        drive(255, 255, 0,   1'b0, 1'b0, 1'b1, 1'b1, 60,  256, 255);
        drive(255, 0, 255,   1'b0, 1'b0, 1'b1, 1'b1, 300, 256, 255);
        drive(255, 0, 128,   1'b0, 1'b0, 1'b1, 1'b1, 330, 256, 255);
        drive(0, 128, 255,   1'b0, 1'b0, 1'b1, 1'b1, 210, 256, 255);
        // single-cycle sync pulses, each on its own pixel
        drive(10, 20, 30,    1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(200, 50, 100,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        drive(40, 90, 60,    1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive(70, 30, 220,   1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(1, 2, 3,       1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) rand_pix();

        // reset with pixels still in the pipeline
        do_reset();
        for (int i = 0; i < 300; i++) rand_pix();

        repeat (8) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
